// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag bit positions
// and FSM state encoding.
package alu_pkg;

  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_MUL    = 8'h03;
  localparam logic [7:0] OP_AND    = 8'h04;
  localparam logic [7:0] OP_OR     = 8'h05;
  localparam logic [7:0] OP_NOT    = 8'h06;
  localparam logic [7:0] OP_XOR    = 8'h07;
  localparam logic [7:0] OP_LSHIFT = 8'h08;
  localparam logic [7:0] OP_RSHIFT = 8'h09;

  localparam int FLAG_W    = 4;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_CARRY = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Callers zero-extend their opcode to 32 bits so any OP_W up to 32 is covered.
  function automatic logic is_legal_op(input logic [31:0] op);
    logic legal_s;
    case (op)
      {24'h000000, OP_ADD},
      {24'h000000, OP_SUB},
      {24'h000000, OP_MUL},
      {24'h000000, OP_AND},
      {24'h000000, OP_OR},
      {24'h000000, OP_NOT},
      {24'h000000, OP_XOR},
      {24'h000000, OP_LSHIFT},
      {24'h000000, OP_RSHIFT}: legal_s = 1'b1;
      default:                 legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle between dispatch logic (master) and
// the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 8,
  parameter int TAG_W  = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [TAG_W-1:0]  cmd_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable. Reads are from the registered head, no write bypass.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1'b1);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered tagged commands to a combinational ALU one at a time and returns
// in-order tagged responses. Define ALU_ISSUE_STATS_EN to add issue/error counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int OP_W       = 8,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_output,
  input  logic              zero_flag,
  input  logic              negative_flag,
  input  logic              overflow_flag,
  input  logic              carry_flag
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [15:0]       stat_errors
`endif
);

  localparam int ENTRY_W = 2 * DATA_W + OP_W + TAG_W;
  localparam int CNT_W   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [ENTRY_W-1:0] fifo_wr_s;
  logic [ENTRY_W-1:0] fifo_rd_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               push_s;
  logic               pop_s;

  logic [DATA_W-1:0]  head_a_s;
  logic [DATA_W-1:0]  head_b_s;
  logic [OP_W-1:0]    head_op_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic               head_legal_s;

  state_e             state_r;
  state_e             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               cnt_zero_s;

  logic               issue_s;
  logic               load_err_s;
  logic               capture_s;
  logic [FLAG_W-1:0]  alu_flags_s;

  logic [DATA_W-1:0]  a_r;
  logic [DATA_W-1:0]  b_r;
  logic [OP_W-1:0]    op_r;
  logic               rsp_valid_r;
  logic [DATA_W-1:0]  rsp_data_r;
  logic [FLAG_W-1:0]  rsp_flags_r;
  logic [TAG_W-1:0]   rsp_tag_r;
  logic               rsp_err_r;

  // cmd_ready is forced low while reset is asserted, independent of FIFO state.
  assign bus.cmd_ready = ~fifo_full_s & rst_n;
  assign push_s        = bus.cmd_valid & bus.cmd_ready;
  assign fifo_wr_s     = {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};
  assign {head_a_s, head_b_s, head_op_s, head_tag_s} = fifo_rd_s;
  assign head_legal_s  = is_legal_op(32'(head_op_s));
  assign cnt_zero_s    = (cnt_r == {CNT_W{1'b0}});

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (fifo_wr_s),
    .rd_data (fifo_rd_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          if (head_legal_s) begin
            next_state_s = EXEC;
          end else begin
            next_state_s = RESP;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_zero_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = EXEC;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode: pop/issue/error/capture strobes
  always_comb begin
    pop_s      = 1'b0;
    issue_s    = 1'b0;
    load_err_s = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          if (head_legal_s) begin
            issue_s = 1'b1;
          end else begin
            load_err_s = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      EXEC: begin
        if (cnt_zero_s) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      RESP:    pop_s = 1'b0;
      default: pop_s = 1'b0;
    endcase
  end

  // Flag vector assembled in the response bit order
  always_comb begin
    alu_flags_s            = {FLAG_W{1'b0}};
    alu_flags_s[FLG_ZERO]  = zero_flag;
    alu_flags_s[FLG_NEG]   = negative_flag;
    alu_flags_s[FLG_OVF]   = overflow_flag;
    alu_flags_s[FLG_CARRY] = carry_flag;
  end

  // ALU operand registers; hold their last issued values between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= {DATA_W{1'b0}};
      b_r  <= {DATA_W{1'b0}};
      op_r <= {OP_W{1'b0}};
    end else if (issue_s) begin
      a_r  <= head_a_s;
      b_r  <= head_b_s;
      op_r <= head_op_s;
    end
  end

  // ALU latency down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (issue_s) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == EXEC) && !cnt_zero_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Response registers; stable while waiting for rsp_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_flags_r <= {FLAG_W{1'b0}};
      rsp_tag_r   <= {TAG_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= (next_state_s == RESP);
      if (capture_s) begin
        rsp_data_r  <= alu_output;
        rsp_flags_r <= alu_flags_s;
        rsp_err_r   <= 1'b0;
      end else if (load_err_s) begin
        rsp_data_r  <= {DATA_W{1'b0}};
        rsp_flags_r <= {FLAG_W{1'b0}};
        rsp_tag_r   <= head_tag_s;
        rsp_err_r   <= 1'b1;
      end else if (issue_s) begin
        // Tag is latched at issue; the response is not yet valid so this is invisible.
        rsp_tag_r   <= head_tag_s;
      end
    end
  end

  assign A             = a_r;
  assign B             = b_r;
  assign alu_operation = op_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_flags = rsp_flags_r;
  assign bus.rsp_tag   = rsp_tag_r;
  assign bus.rsp_err   = rsp_err_r;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued_r;
  logic [15:0] stat_errors_r;

  // Saturating issue and error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_r <= 32'd0;
      stat_errors_r <= 16'd0;
    end else begin
      if (issue_s && (stat_issued_r != 32'hFFFF_FFFF)) begin
        stat_issued_r <= stat_issued_r + 32'd1;
      end
      if (load_err_s && (stat_errors_r != 16'hFFFF)) begin
        stat_errors_r <= stat_errors_r + 16'd1;
      end
    end
  end

  assign stat_issued = stat_issued_r;
  assign stat_errors = stat_errors_r;
`endif

endmodule
